// File: rtl/ov_dvp_pattern_tx.sv
// ov_dvp_pattern_tx: OV-style DVP source emitting VSYNC/HREF framed RGB565 test patterns, high byte first.
module ov_dvp_pattern_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 288,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        OV_PCLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:0]  PATTERN_SEL,
  input  logic [15:0] SOLID,
  output logic        OV_VSYNC,
  output logic        OV_HREF,
  output logic [7:0]  OV_DVP,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_CNT,
  output logic        BUSY
);
  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int HW        = $clog2(LINE_CLKS);
  localparam int BAR_BYTES = H_ACTIVE / 4;
  localparam int BW        = $clog2(BAR_BYTES + 1);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [15:0]     line_q, line_d, lines;
  logic [2:0]      bar_q, bar_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]      pat_q, pat_d;
  logic [15:0]     solid_q, solid_d, pix, cnt_q, cnt_d;
  logic [7:0]      x, y, dvp_q, dvp_d;
  logic            line_end, state_end, frame_start;
  logic            vsync_q, vsync_d, href_q, href_d, done_q, done_d, busy_q, busy_d;
  // Outputs are registered from the next-state values so they line up with the state register.
  always_comb begin
    lines = state_q == VSYNC ? 16'(VS_LINES) : state_q == VBP ? 16'(VBP_LINES) :
            state_q == ACTIVE ? 16'(V_ACTIVE) : 16'(VFP_LINES);
    line_end = h_q == HW'(LINE_CLKS - 1);
    state_end = line_end && line_q == lines - 16'd1;
    state_d = state_q;
    h_d = line_end ? '0 : h_q + HW'(1);
    line_d = state_end ? 16'd0 : line_end ? line_q + 16'd1 : line_q;
    if (state_q == IDLE) begin
      h_d = '0;
      line_d = 16'd0;
      state_d = EN ? VSYNC : IDLE;
    end else if (state_end) begin
      state_d = state_q == VSYNC ? VBP : state_q == VBP ? ACTIVE : state_q == ACTIVE ? VFP :
                EN ? VSYNC : IDLE;
    end
    frame_start = state_d == VSYNC && state_q != VSYNC;
    pat_d = frame_start ? PATTERN_SEL : pat_q;
    solid_d = frame_start ? SOLID : solid_q;
    bar_d = h_d == '0 ? 3'd0 : bcnt_q == BW'(BAR_BYTES - 1) ? bar_q + 3'd1 : bar_q;
    bcnt_d = h_d == '0 || bcnt_q == BW'(BAR_BYTES - 1) ? '0 : bcnt_q + BW'(1);
    x = 8'(h_d >> 1);
    y = 8'(line_d);
    pix = pat_q == 2'd0 ? BARS[bar_d] : pat_q == 2'd1 ? {y, x} : pat_q == 2'd2 ? solid_q :
          (x[3] ^ y[3]) ? 16'h0000 : 16'hFFFF;
    href_d = state_d == ACTIVE && h_d < HW'(2 * H_ACTIVE);
    dvp_d = href_d ? (h_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    vsync_d = state_d == VSYNC;
    busy_d = state_d != IDLE;
    done_d = state_d == VFP && h_d == HW'(LINE_CLKS - 1) && line_d == 16'(VFP_LINES - 1);
    cnt_d = done_d ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge OV_PCLK) begin
    if (RST) begin
      state_q <= IDLE;
      h_q <= '0;
      line_q <= 16'd0;
      bar_q <= 3'd0;
      bcnt_q <= '0;
      pat_q <= 2'd0;
      solid_q <= 16'd0;
      cnt_q <= 16'd0;
      dvp_q <= 8'h00;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      line_q <= line_d;
      bar_q <= bar_d;
      bcnt_q <= bcnt_d;
      pat_q <= pat_d;
      solid_q <= solid_d;
      cnt_q <= cnt_d;
      dvp_q <= dvp_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign OV_VSYNC = vsync_q;
  assign OV_HREF = href_q;
  assign OV_DVP = dvp_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT = cnt_q;
  assign BUSY = busy_q;
endmodule

// File: tb/tb_ov_dvp_pattern_tx.sv
// tb_ov_dvp_pattern_tx: frame timing, pattern bytes via scoreboard, loopback capture, EN drop and reset abort.
module tb_ov_dvp_pattern_tx;
  localparam int HA = 8, VA = 4, LINE = 20, FRAME = 140;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [15:0] solid = 16'd0;
  logic vsync, href, done, busy;
  logic [7:0] dvp;
  logic [15:0] fcnt;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;
  bit sb_on = 1'b1;
  logic [7:0] cap_hi;
  bit cap_ph;
  int cap_words = 0, cap_bad = 0;
  logic [15:0] cap_exp = 16'h0000, cap_word;

  always #5 clk = ~clk;

  ov_dvp_pattern_tx #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut (
    .OV_PCLK(clk), .RST(rst), .EN(en), .PATTERN_SEL(sel), .SOLID(solid),
    .OV_VSYNC(vsync), .OV_HREF(href), .OV_DVP(dvp), .FRAME_DONE(done), .FRAME_CNT(fcnt), .BUSY(busy));

  // scoreboard consumer: every valid byte is popped and compared
  always @(negedge clk) begin
    if (sb_on && href) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: got byte %02h, expected nothing", dvp);
      end else begin
        exp_b = sb.pop_front();
        if (dvp !== exp_b) begin
          n_bad++;
          $display("FAIL sb_byte: got %02h expected %02h", dvp, exp_b);
        end
      end
    end
  end

  // capture receiver: pairs bytes starting at HREF rise, high byte first
  always @(negedge clk) begin
    if (vsync) begin
      cap_words = 0;
      cap_bad = 0;
      cap_ph = 1'b0;
    end else if (href) begin
      if (!cap_ph) cap_hi = dvp;
      else begin
        cap_word = {cap_hi, dvp};
        cap_words++;
        if (cap_word !== cap_exp) cap_bad++;
      end
      cap_ph = ~cap_ph;
    end else cap_ph = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_pix(input logic [1:0] s, input logic [15:0] so, input int x, input int y);
    logic [15:0] bar;
    case (x / (HA / 8))
      0: bar = 16'hFFFF;
      1: bar = 16'hFFE0;
      2: bar = 16'h07FF;
      3: bar = 16'h07E0;
      4: bar = 16'hF81F;
      5: bar = 16'hF800;
      6: bar = 16'h001F;
      default: bar = 16'h0000;
    endcase
    case (s)
      2'd0: return bar;
      2'd1: return {8'(y), 8'(x)};
      2'd2: return so;
      default: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'h0000 : 16'hFFFF;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] s, input logic [15:0] so);
    logic [15:0] p;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++) begin
        p = exp_pix(s, so, xx, yy);
        sb.push_back(p[15:8]);
        sb.push_back(p[7:0]);
      end
  endtask

  task automatic run_frame(input logic [1:0] s, input logic [15:0] so, input int drop_at, output int wait_cyc);
    int vs_n, vs_last, rises, first_rise, last_rise, href_n, done_n, done_at, dvp_bad, busy_low;
    logic [15:0] c0;
    logic ph;
    sel = s;
    solid = so;
    push_frame(s, so);
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!vsync && wait_cyc < 300);
    n_cmp++;
    if (!vsync) begin
      n_bad++;
      $display("FAIL vsync_start: no VSYNC within %0d cycles", wait_cyc);
      return;
    end
    vs_n = 0; vs_last = -1; rises = 0; first_rise = -1; last_rise = -1;
    href_n = 0; done_n = 0; done_at = -1; dvp_bad = 0; busy_low = 0; ph = 1'b0;
    c0 = fcnt;
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) @(negedge clk);
      if (t == drop_at) en = 1'b0;
      if (vsync) begin vs_n++; vs_last = t; end
      if (href && !ph) begin rises++; if (first_rise < 0) first_rise = t; last_rise = t; end
      ph = href;
      if (href) href_n++;
      if (!href && dvp !== 8'h00) dvp_bad++;
      if (done) begin done_n++; done_at = t; end
      if (!busy) busy_low++;
    end
    n_cmp++;
    if (vs_n != LINE || vs_last != LINE - 1) begin n_bad++; $display("FAIL vsync_width: got %0d cycles ending %0d, expected 20 ending 19", vs_n, vs_last); end
    n_cmp++;
    if (first_rise != 2 * LINE) begin n_bad++; $display("FAIL href_first: got %0d expected 40", first_rise); end
    n_cmp++;
    if (rises != VA || last_rise != 5 * LINE) begin n_bad++; $display("FAIL href_pulses: got %0d rises last %0d, expected 4 last 100", rises, last_rise); end
    n_cmp++;
    if (href_n != 2 * HA * VA) begin n_bad++; $display("FAIL href_bytes: got %0d expected 64", href_n); end
    n_cmp++;
    if (dvp_bad != 0) begin n_bad++; $display("FAIL dvp_idle: %0d nonzero bytes with HREF low, expected 0", dvp_bad); end
    n_cmp++;
    if (done_n != 1 || done_at != FRAME - 1) begin n_bad++; $display("FAIL frame_done: got %0d pulses at %0d, expected 1 at 139", done_n, done_at); end
    n_cmp++;
    if (fcnt !== 16'(c0 + 16'd1)) begin n_bad++; $display("FAIL frame_cnt: got %0d expected %0d", fcnt, c0 + 16'd1); end
    n_cmp++;
    if (busy_low != 0) begin n_bad++; $display("FAIL busy_frame: low for %0d cycles, expected 0", busy_low); end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_left: %0d bytes left, expected 0", sb.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({vsync, href, dvp, done, busy} !== 12'd0) begin n_bad++; $display("FAIL reset_outputs: got vs=%b hr=%b dvp=%02h done=%b busy=%b, expected all 0", vsync, href, dvp, done, busy); end
    n_cmp++;
    if (fcnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", fcnt); end
    rst = 1'b0;
  endtask

  task automatic test_frame_timing();
    int w;
    run_frame(2'd1, 16'h0000, -1, w);
    n_cmp++;
    if (w != 1) begin n_bad++; $display("FAIL vsync_latency: got %0d expected 1", w); end
  endtask

  task automatic test_back_to_back_bars();
    int w;
    run_frame(2'd0, 16'h0000, -1, w);
    n_cmp++;
    if (w != 1) begin n_bad++; $display("FAIL back_to_back: VSYNC after %0d cycles, expected 1", w); end
  endtask

  task automatic test_loopback_solid();
    int w;
    cap_exp = 16'hF81F;
    run_frame(2'd2, 16'hF81F, -1, w);
    n_cmp++;
    if (cap_words != HA * VA) begin n_bad++; $display("FAIL cap_words: got %0d expected 32", cap_words); end
    n_cmp++;
    if (cap_bad != 0) begin n_bad++; $display("FAIL cap_value: %0d words differ from F81F, expected 0", cap_bad); end
  endtask

  task automatic test_en_drop();
    int w, vs_seen, done_seen;
    run_frame(2'd3, 16'h0000, 70, w);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b expected 0", busy); end
    vs_seen = 0;
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (vsync) vs_seen++;
      if (done) done_seen++;
    end
    n_cmp++;
    if (vs_seen != 0 || done_seen != 0) begin n_bad++; $display("FAIL no_restart: vsync %0d done %0d cycles, expected 0 0", vs_seen, done_seen); end
    n_cmp++;
    if (fcnt !== 16'd4) begin n_bad++; $display("FAIL frame_cnt_total: got %0d expected 4", fcnt); end
  endtask

  task automatic test_reset_mid();
    int w, act;
    sb_on = 1'b0;
    en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!vsync && w < 10);
    repeat (65) @(negedge clk);
    n_cmp++;
    if (href !== 1'b1) begin n_bad++; $display("FAIL mid_active_href: got %b expected 1", href); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({vsync, href, dvp, done, busy} !== 12'd0 || fcnt !== 16'd0) begin n_bad++; $display("FAIL reset_mid: got vs=%b hr=%b dvp=%02h done=%b busy=%b cnt=%0d, expected all 0", vsync, href, dvp, done, busy, fcnt); end
    en = 1'b0;
    rst = 1'b0;
    act = 0;
    repeat (50) begin
      @(negedge clk);
      if (vsync || done || busy) act++;
    end
    n_cmp++;
    if (act != 0) begin n_bad++; $display("FAIL reset_mid_quiet: %0d active cycles, expected 0", act); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_back_to_back_bars();
    test_loopback_solid();
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
